sds_frame_tx: RTL

Transmit-side framer for the SFP event link. It builds the 16-bit word stream for the GTP transmitter's `tx_data`/`txcharisk` inputs:
- The low byte carries event codes and periodic K28.5 commas.
- The high byte interleaves the distributed-bus byte and the segmented-data-buffer frame.

It is the upstream counterpart of `shared_data_rx_wrapper` and replaces the simulation-only frame generator in synthesis.

---
 rtl/sds_frame_tx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sds_frame_tx.sv
// Transmit framer for the SFP event link: the low byte carries events and K28.5 commas, the high byte carries dbus and segment frames.
// Optional build macro SDS_TX_DBUS_EN puts dbus on the even-slot high byte; without it those bytes are 0x00.
module sds_frame_tx #(
    parameter int COMMA_PERIOD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic        seg_wr_en,
    input  logic [3:0]  seg_wr_addr,
    input  logic [7:0]  seg_wr_data,
    input  logic [7:0]  seg_addr,
    input  logic        send,
    output logic        busy,
    output logic        frame_done,
    input  logic [7:0]  event_code,
    input  logic        event_valid,
    output logic        event_ready,
    input  logic [7:0]  dbus,
    output logic [15:0] tx_data,
    output logic [1:0]  tx_is_k
);
    localparam int CW = $clog2(COMMA_PERIOD);
    localparam logic [CW-1:0] CLAST = CW'(COMMA_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_DATA, S_STOP, S_CSUM_HI, S_CSUM_LO
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    didx, didx_nxt;
    logic          phase;
    logic [CW-1:0] ccnt;
    logic [7:0]    stage  [16];
    logic [7:0]    shadow [16];
    logic [7:0]    addr_q;
    logic [15:0]   csum_q;
    logic [15:0]   stage_sum;
    logic [7:0]    seg_byte, dbus_byte;
    logic          seg_k, done_nxt, accept, comma;

    assign accept      = send && !busy && ready;
    assign comma       = (ccnt == '0);
    assign event_ready = (ccnt != '0);

`ifdef SDS_TX_DBUS_EN
    assign dbus_byte = dbus;
`else
    logic dbus_unused;
    assign dbus_byte   = 8'h00;
    assign dbus_unused = ^dbus;
`endif

    // Checksum is taken from the staging contents the shadow copy captures.
    always_comb begin
        stage_sum = {8'h00, seg_addr};
        for (int j = 0; j < 16; j++)
            stage_sum = stage_sum + {8'h00, stage[j]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 16; j++) begin
                stage[j]  <= 8'h00;
                shadow[j] <= 8'h00;
            end
        end else begin
            if (accept)
                for (int j = 0; j < 16; j++) shadow[j] <= stage[j];
            if (seg_wr_en)
                stage[seg_wr_addr] <= seg_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            didx  <= 4'd0;
        end else if (!ready) begin
            state <= S_IDLE;
            didx  <= 4'd0;
        end else begin
            state <= state_nxt;
            didx  <= didx_nxt;
        end
    end

    // Frame sequencing only moves on odd slots; accept arms START for the next odd slot.
    always_comb begin
        state_nxt = state;
        didx_nxt  = didx;
        seg_byte  = 8'h00;
        seg_k     = 1'b0;
        done_nxt  = 1'b0;
        if (phase) begin
            case (state)
                S_START: begin
                    seg_byte  = 8'h5C;
                    seg_k     = 1'b1;
                    state_nxt = S_ADDR;
                end
                S_ADDR: begin
                    seg_byte  = addr_q;
                    didx_nxt  = 4'd0;
                    state_nxt = S_DATA;
                end
                S_DATA: begin
                    seg_byte = shadow[didx];
                    didx_nxt = didx + 4'd1;
                    if (didx == 4'd15) state_nxt = S_STOP;
                end
                S_STOP: begin
                    seg_byte  = 8'h3C;
                    seg_k     = 1'b1;
                    state_nxt = S_CSUM_HI;
                end
                S_CSUM_HI: begin
                    seg_byte  = csum_q[15:8];
                    state_nxt = S_CSUM_LO;
                end
                S_CSUM_LO: begin
                    seg_byte  = csum_q[7:0];
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: ;
            endcase
        end
        if (accept) state_nxt = S_START;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase      <= 1'b0;
            ccnt       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            tx_data    <= 16'h0000;
            tx_is_k    <= 2'b00;
            addr_q     <= 8'h00;
            csum_q     <= 16'h0000;
        end else if (!ready) begin
            phase      <= 1'b0;
            ccnt       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            tx_data    <= 16'h0000;
            tx_is_k    <= 2'b00;
        end else begin
            phase      <= ~phase;
            ccnt       <= (ccnt == CLAST) ? '0 : ccnt + 1'b1;
            frame_done <= done_nxt;
            if (accept) begin
                busy   <= 1'b1;
                addr_q <= seg_addr;
                csum_q <= ~stage_sum;
            end else if (done_nxt) begin
                busy <= 1'b0;
            end
            tx_data <= {phase ? seg_byte : dbus_byte,
                        comma ? 8'hBC : (event_valid ? event_code : 8'h00)};
            tx_is_k <= {phase & seg_k, comma};
        end
    end
endmodule
